// File: rtl/fm_audio_interp.sv
// Audio-rate to clock-rate linear interpolator for the FM modulator's audio input.
// Samples arrive through a small FIFO; each segment spans 2^LOG2_RATIO clocks.
module fm_audio_interp #(
  parameter int LOG2_RATIO = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          clr_underrun,
  output logic [15:0]                   audio,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int L    = LOG2_RATIO;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int ACCW = 16 + L;

  typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

  logic [15:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    full, empty, push, pop;
  logic [15:0]             head;

  state_t                  state, state_n;
  logic [15:0]             nxt;
  logic signed [16:0]      delta;
  logic signed [ACCW-1:0]  acc;
  logic [L-1:0]            phase;
  logic                    set_ur;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = s_valid && !full;
  assign head       = mem[rd_ptr];
  assign s_ready    = !full;
  assign fifo_level = count;
  assign audio      = acc[ACCW-1:L];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    set_ur  = 1'b0;
    case (state)
      IDLE, STARVE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (&phase) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = STARVE;
            set_ur  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      nxt      <= '0;
      delta    <= '0;
      acc      <= '0;
      phase    <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      // acc lands exactly on nxt*R at the last phase, so the new delta is taken from nxt
      if (pop) begin
        nxt   <= head;
        delta <= $signed({head[15], head}) - $signed({nxt[15], nxt});
      end
      if (state == RUN) begin
        acc   <= acc + ACCW'(delta);
        phase <= phase + L'(1);
      end else if (pop) begin
        phase <= '0;
      end
      if (set_ur)            underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_audio_interp.sv
// Scoreboard bench for fm_audio_interp (R = 4, depth 4): stimulus queues the expected
// audio steps, a negedge monitor pops and compares each change of audio.
module tb_fm_audio_interp;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic [15:0] audio;
  logic        underrun;
  logic [2:0]  fifo_level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  logic        mon_en = 1'b0;
  logic [15:0] prev_audio = '0;

  fm_audio_interp #(.LOG2_RATIO(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .clr_underrun(clr_underrun), .audio(audio), .underrun(underrun), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: every change in audio must match the queue head
  always @(negedge clk) begin
    if (mon_en && (audio !== prev_audio)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_audio actual=%0d expected=none", $signed(audio));
      end else begin
        chk("audio_step", int'($signed(audio)), exp_q.pop_front());
      end
    end
    prev_audio = audio;
  end

  task automatic push(input int v, output int acc_cyc);
    logic rdy;
    int n;
    s_data  = 16'(v);
    s_valid = 1'b1;
    n = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      chk("s_ready_vs_level", int'(s_ready), int'(fifo_level != 3'd4));
      @(posedge clk);
      if (rdy) acc_cyc = cyc;
      #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic ramp(input int from, input int to);
    for (int j = 1; j <= 4; j++) exp_q.push_back(from + ((to - from) * j) / 4);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c;
  int last_c;
  int v;
  int prev_v;
  logic saw_full;

  initial begin
    rst_n = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    clr_underrun = 1'b0;
    #17 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // reset state held with no input
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_audio", int'(audio), 0);
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_level", int'(fifo_level), 0);
    end
    @(posedge clk); #1;

    // 400 then 800 back to back
    for (int k = 1; k <= 8; k++) exp_q.push_back(100 * k);
    push(400, c);
    chk("level_after_push", int'(fifo_level), 1);
    push(800, c);
    wait_cycles(3);
    chk("audio_edge4", int'($signed(audio)), 300);
    wait_cycles(1);
    chk("audio_edge5", int'($signed(audio)), 400);
    wait_cycles(12);
    chk("hold_800", int'($signed(audio)), 800);
    chk("underrun_set", int'(underrun), 1);
    clr_underrun = 1'b1;
    wait_cycles(1);
    clr_underrun = 1'b0;
    chk("underrun_clr", int'(underrun), 0);

    // negative delta with floor rounding
    exp_q.push_back(599); exp_q.push_back(398); exp_q.push_back(197); exp_q.push_back(-3);
    push(-3, c);
    wait_cycles(10);
    chk("settle_m3", int'($signed(audio)), -3);

    // full-scale extremes
    exp_q.push_back(8189); exp_q.push_back(16382); exp_q.push_back(24574); exp_q.push_back(32767);
    push(32767, c);
    wait_cycles(10);
    chk("settle_max", int'($signed(audio)), 32767);
    exp_q.push_back(16383); exp_q.push_back(-1); exp_q.push_back(-16385); exp_q.push_back(-32768);
    push(-32768, c);
    wait_cycles(10);
    chk("settle_min", int'($signed(audio)), -32768);

    // continuous s_valid with incrementing data
    saw_full = 1'b0;
    prev_v = -32768;
    last_c = 0;
    for (int k = 0; k < 12; k++) begin
      v = -32768 + 400 * (k + 1);
      ramp(prev_v, v);
      push(v, c);
      if (fifo_level == 3'd4 && !s_ready) saw_full = 1'b1;
      if (k >= 6) chk("accept_gap", c - last_c, 4);
      last_c = c;
      prev_v = v;
    end
    chk("saw_full", int'(saw_full), 1);
    wait_cycles(60);
    chk("flow_final", int'($signed(audio)), prev_v);
    chk("flow_queue_empty", exp_q.size(), 0);

    // asynchronous reset mid-segment
    ramp(prev_v, 4000);
    push(4000, c);
    wait_cycles(3);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_audio", int'(audio), 0);
    chk("midrst_level", int'(fifo_level), 0);
    exp_q.delete();
    wait_cycles(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(100 * k);
    push(400, c);
    wait_cycles(10);
    chk("post_rst_final", int'($signed(audio)), 400);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_audio_interp.md
# fm_audio_interp

Audio-rate to clock-rate interpolator that feeds the FM modulator's 16-bit `audio` input. Accepts signed 16-bit audio samples over a valid/ready handshake into a small FIFO. Produces a new output value every `clk` by linear interpolation between consecutive samples, with 2^LOG2_RATIO clocks per input sample. Without it, the modulator would see step discontinuities at each sample update, causing spectral splatter.

## Interface
- LOG2_RATIO, 6: clocks per input sample R = 2^LOG2_RATIO; legal range 1..10
- FIFO_DEPTH, 4: input FIFO entries, power of two, ≥2
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  16  signed two's-complement audio sample
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; equals !full
- clr_underrun  in  1  synchronous clear of underrun flag
- audio  out  16  signed interpolated sample, one per clk, to modulator
- underrun  out  1  sticky: interpolator ran out of samples
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: write on s_valid && s_ready, read (pop) under FSM control; no bypass, so a pushed word is poppable the cycle after acceptance; simultaneous push and pop legal; s_ready low when full, so no overflow possible.
- Registers: `nxt` (16b, segment end point), `delta` (17b signed), `acc` (16+L bits signed), `phase` (L bits), state.
- audio = acc[L+15:L] (arithmetic floor of acc / R); always a registered value.
- States:
  - IDLE: after reset; acc = 0, nxt = 0. If FIFO is non-empty: pop head h, nxt <= h, delta <= h − nxt, phase <= 0, go to RUN.
  - RUN: every cycle acc <= acc + delta, phase <= phase + 1 (wraps). On the cycle with phase == R−1, acc becomes exactly nxt·R. In that same cycle:
    - if FIFO is non-empty: pop h, delta <= h − nxt, nxt <= h, stay in RUN;
    - else go to STARVE and set underrun.
  - STARVE: acc holds (audio = old nxt). When FIFO is non-empty: pop and load exactly as on an IDLE pop, phase <= 0, go to RUN.
- Arithmetic: delta = sign-extended h − nxt, range −65535..65535. acc stays between the segment end points · R, so 16+L bits never overflow. No saturation logic is required.
- underrun: set on entry to STARVE; cleared by clr_underrun unless a set occurs in the same cycle (set wins).
- Reset mid-operation, asynchronously: FIFO emptied, state IDLE, all registers zeroed.

## Timing
- Reset values: audio = 0, s_ready = 1, underrun = 0, fifo_level = 0, state IDLE.
- The first sample is accepted at edge 0 and popped at edge 1. audio then steps at edges 2..R+1 and equals the sample after edge R+1.
- In steady state, one sample is consumed every R clocks. audio reaches each sample value exactly at the segment boundary, with no extra hold cycle.
- A STARVE→RUN transition adds the number of stall cycles to the segment; audio is flat throughout the stall.
- fifo_level updates the cycle after each push or pop; push and pop in the same cycle leave it unchanged.

## Test plan
All directed tests use LOG2_RATIO = 2 (R = 4) and FIFO_DEPTH = 4.
- Reset, no input → audio = 0, s_ready = 1, underrun = 0, fifo_level = 0 held for 20 cycles.
- Push 400, then 800 back-to-back → audio sequence 100, 200, 300, 400, 500, 600, 700, 800, then holds at 800 with underrun = 1. clr_underrun pulse → underrun = 0.
- From steady 800, push −3 → audio 599, 398, 197, −3 (floor rounding on negative delta).
- Push 32767, then −32768 after settling → audio rises to 32767, then 16383, −1, −16385, −32768. No wrap occurs.
- Hold s_valid high continuously with incrementing data → s_ready drops when fifo_level = 4. One push is accepted per 4 clocks thereafter. No sample is lost or duplicated, checked against a reference model.
- Deassert rst_n mid-segment, asynchronously between edges → audio = 0 and fifo_level = 0 immediately. After release, the next sample ramps from 0.
